ysyx_24070017_rf_wb_arb: RTL and testbench

YSYX_24070017_RF_WB_ARB -- requirements
Module: ysyx_24070017_rf_wb_arb

---
 rtl/ysyx_24070017_rf_wb_arb_pkg.sv | 18 +
 rtl/ysyx_24070017_rr_arb.sv | 34 +++
 rtl/ysyx_24070017_rf_wb_arb.sv | 128 ++++++++++++
 tb/tb_ysyx_24070017_rf_wb_arb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070017_rf_wb_arb_pkg.sv
// Shared configuration for the register-file writeback path: default widths,
// requester indices and the index-width helper used by the arbiter and its top.
package ysyx_24070017_rf_wb_arb_pkg;

    localparam int WORD_LENGTH_DEF = 32;
    localparam int RF_REG_NUM_DEF  = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;
    localparam int NREQ_DEF = REQ_CSR + 1;

    // Width needed to index n entries; never below 1 so ports stay legal.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24070017_rr_arb.sv
// Combinational round-robin grant: the first valid requester at or after ptr
// (wrapping modulo NREQ) receives a one-hot grant.
module ysyx_24070017_rr_arb
    import ysyx_24070017_rf_wb_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int PW = addr_width(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant = '0;
        sum   = '0;
        idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            sum = {1'b0, ptr} + (PW + 1)'(off);
            if (sum >= (PW + 1)'(NREQ)) begin
                sum = sum - (PW + 1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ysyx_24070017_rf_wb_arb.sv
// Writeback arbiter for the register file: round-robin grant among requesters,
// one registered write per cycle, optional busy scoreboard (YSYX_24070017_RF_SCOREBOARD_EN).
module ysyx_24070017_rf_wb_arb
    import ysyx_24070017_rf_wb_arb_pkg::*;
#(
    parameter int WORD_LENGTH = WORD_LENGTH_DEF,
    parameter int RF_REG_NUM  = RF_REG_NUM_DEF,
    parameter int NREQ        = NREQ_DEF,
    localparam int AW = addr_width(RF_REG_NUM)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_valid,
    output logic [NREQ-1:0]                   req_ready,
    input  logic [NREQ*AW-1:0]                req_addr,
    input  logic [NREQ*WORD_LENGTH-1:0]       req_data,
    input  logic                              rsv_valid,
    input  logic [AW-1:0]                     rsv_addr,
    input  logic [2*AW-1:0]                   rd_addr,
    output logic [1:0]                        rd_busy,
    output logic [RF_REG_NUM-1:0]             rf_we,
    output logic [RF_REG_NUM*WORD_LENGTH-1:0] rf_wdata,
    output logic [RF_REG_NUM-1:0]             rf_rst
);

    localparam int PW = addr_width(NREQ);

    logic [PW-1:0]          rr_ptr_reg, rr_ptr_next;
    logic [NREQ-1:0]        grant;
    logic                   xfer;
    logic [PW-1:0]          win_idx;
    logic [AW-1:0]          win_addr;
    logic [WORD_LENGTH-1:0] win_data;
    logic [RF_REG_NUM-1:0]  we_reg;
    logic [WORD_LENGTH-1:0] wdata_reg;

    ysyx_24070017_rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    // Nothing is accepted while reset is held, so in-flight requests are dropped.
    assign req_ready = rst ? '0 : grant;
    assign xfer      = |req_ready;

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                win_idx  = PW'(i);
                win_addr = req_addr[i*AW +: AW];
                win_data = req_data[i*WORD_LENGTH +: WORD_LENGTH];
            end
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (xfer) begin
            rr_ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            we_reg     <= '0;
            wdata_reg  <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            we_reg     <= '0;
            if (xfer) begin
                wdata_reg <= win_data;
                // x0 is hardwired: the write is accepted but never enabled.
                if (win_addr != '0) begin
                    we_reg[win_addr] <= 1'b1;
                end
            end
        end
    end

    assign rf_we  = we_reg;
    assign rf_rst = {RF_REG_NUM{rst}};

    generate
        for (genvar gi = 0; gi < RF_REG_NUM; gi++) begin : g_wdata
            assign rf_wdata[gi*WORD_LENGTH +: WORD_LENGTH] = wdata_reg;
        end
    endgenerate

`ifdef YSYX_24070017_RF_SCOREBOARD_EN
    logic [RF_REG_NUM-1:0] busy_reg, busy_next;

    // Reserve is applied after the clear so a same-edge reserve keeps the bit set.
    always_comb begin
        busy_next = busy_reg;
        if (xfer) begin
            busy_next[win_addr] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_busy
            assign rd_busy[gi] = busy_reg[rd_addr[gi*AW +: AW]];
        end
    endgenerate
`else
    logic unused_inputs;
    assign unused_inputs = ^{rsv_valid, rsv_addr, rd_addr};
    assign rd_busy       = '0;
`endif

endmodule

// File: tb/tb_ysyx_24070017_rf_wb_arb.sv
// Directed bench for the writeback arbiter: expected register-file writes are
// queued at issue and checked by an independent monitor on each falling edge.
module tb_ysyx_24070017_rf_wb_arb;

    localparam int AW = 5;
    localparam int WL = 32;
    localparam int NR = 32;
    localparam int NQ = 3;

`ifdef YSYX_24070017_RF_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NQ-1:0]      req_valid;
    logic [NQ-1:0]      req_ready;
    logic [NQ*AW-1:0]   req_addr;
    logic [NQ*WL-1:0]   req_data;
    logic               rsv_valid;
    logic [AW-1:0]      rsv_addr;
    logic [2*AW-1:0]    rd_addr;
    logic [1:0]         rd_busy;
    logic [NR-1:0]      rf_we;
    logic [NR*WL-1:0]   rf_wdata;
    logic [NR-1:0]      rf_rst;

    ysyx_24070017_rf_wb_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rf_we     (rf_we),
        .rf_wdata  (rf_wdata),
        .rf_rst    (rf_rst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  edge_n      = 0;
    bit  mon_en      = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Monitor: every falling edge, either the expected write or an idle rf_we.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].tag == edge_n) begin
                e = exp_q.pop_front();
                check($sformatf("rf_we x%0d", e.addr), 64'(rf_we), 64'(1) << e.addr);
                check($sformatf("wdata slot x%0d", e.addr), 64'(rf_wdata[e.addr*WL +: WL]), 64'(e.data));
                check("wdata slot x31", 64'(rf_wdata[31*WL +: WL]), 64'(e.data));
            end else begin
                check("rf_we idle", 64'(rf_we), 64'd0);
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WL-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*WL +: WL] = d;
    endtask

    // Check the expected grant, queue the resulting write, then advance one cycle.
    task automatic step(input string nm, input logic [NQ-1:0] exp_ready);
        logic [AW-1:0] a;
        #1;
        check({nm, " ready"}, 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < NQ; i++) begin
            a = req_addr[i*AW +: AW];
            if (exp_ready[i] && a != '0) begin
                exp_q.push_back('{tag: edge_n + 1, addr: int'(a), data: req_data[i*WL +: WL]});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_busy(input string nm, input logic [1:0] exp);
        #1;
        check(nm, 64'(rd_busy), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        rd_addr   = '0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;

        // Reset holds off a pending request.
        req_valid = 3'b001;
        set_req(0, 5'd9, 32'h0000_0099);
        #1;
        check("rst rf_rst", 64'(rf_rst), 64'hFFFF_FFFF);
        check("rst rf_wdata zero", 64'(rf_wdata == '0), 64'd1);
        check("rst rd_busy", 64'(rd_busy), 64'd0);
        step("rst hold", 3'b000);

        rst = 1'b0;
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        step("alu x5", 3'b001);
        req_valid = '0;
        step("idle", 3'b000);

        rst = 1'b1;
        step("rst2", 3'b000);
        rst = 1'b0;

        // All three requesters valid: rotate 0,1,2 then wrap.
        req_valid = 3'b111;
        set_req(0, 5'd1, 32'h0000_0011);
        set_req(1, 5'd2, 32'h0000_0022);
        set_req(2, 5'd3, 32'h0000_0033);
        step("rr grant0", 3'b001);
        step("rr grant1", 3'b010);
        step("rr grant2", 3'b100);
        req_valid = 3'b011;
        step("ptr wrap", 3'b001);

        req_valid = 3'b010;
        set_req(1, 5'd0, 32'h0000_0001);
        step("lsu x0", 3'b010);

        // Scoreboard: reserve, clear, same-edge reserve+clear.
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        rd_addr   = {5'd3, 5'd7};
        step("rsv x7", 3'b000);
        rsv_valid = 1'b0;
        chk_busy("busy after rsv x7", SB ? 2'b01 : 2'b00);
        step("hold", 3'b000);
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_0077);
        step("alu x7", 3'b001);
        req_valid = '0;
        chk_busy("busy after wr x7", 2'b00);
        step("idle2", 3'b000);
        req_valid = 3'b001;
        set_req(0, 5'd7, 32'h0000_007F);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        step("rsv+wr x7", 3'b001);
        req_valid = '0;
        rsv_valid = 1'b0;
        chk_busy("busy after rsv+wr x7", SB ? 2'b01 : 2'b00);
        step("idle3", 3'b000);

        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        step("rsv x4", 3'b000);
        rsv_valid = 1'b0;
        rd_addr   = {5'd4, 5'd4};
        chk_busy("busy x4 x4", SB ? 2'b11 : 2'b00);
        step("idle4", 3'b000);

        // Transfer attempt to x9 on a reset edge.
        req_valid = 3'b001;
        set_req(0, 5'd9, 32'h0000_0099);
        rst = 1'b1;
        #1;
        check("rst2 rf_rst", 64'(rf_rst), 64'hFFFF_FFFF);
        step("rst x9", 3'b000);
        rst       = 1'b0;
        req_valid = '0;
        rd_addr   = {5'd4, 5'd7};
        chk_busy("busy cleared by rst", 2'b00);
        check("rf_wdata zero after rst", 64'(rf_wdata == '0), 64'd1);
        step("idle5", 3'b000);
        req_valid = 3'b011;
        step("ptr after rst", 3'b001);
        req_valid = '0;
        step("drain1", 3'b000);
        step("drain2", 3'b000);

        check("write queue drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
